vram_arbiter: RTL and testbench

- Schedules the shared frame-buffer memory port between two requesters: the display line fetch and the drawing engine's single-word writes.
- Display fetch has priority and runs in fixed bursts. The block generates the raster-order read address itself and rewinds it at each frame start (VRSTART from the sync generator).
- Sits between the display line FIFO, the draw engine and the memory controller, all on the dot clock.

---
 rtl/vram_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Frame-buffer port arbiter: display burst fetch (priority) versus single-word draw writes.
// Optional `ARB_FAIR_EN forces one pending write after STARVE_LIM back-to-back display bursts.
module vram_arbiter #(
  parameter int AW          = 19,
  parameter int DW          = 16,
  parameter int BURST       = 16,
  parameter int FRAME_WORDS = 307200,
  parameter int STARVE_LIM  = 4
) (
  input  logic          DCLK,
  input  logic          DRST,
  input  logic          VRSTART,
  input  logic          DFIFO_LOW,
  output logic          DRVALID,
  output logic [DW-1:0] DRDATA,
  input  logic          WREQ,
  input  logic [AW-1:0] WADDR,
  input  logic [DW-1:0] WDATA,
  output logic          WACK,
  output logic          MEM_VALID,
  input  logic          MEM_READY,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic          MEM_RVALID,
  input  logic [DW-1:0] MEM_RDATA
);

  localparam int BW = $clog2(BURST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          frame_pend_q, frame_pend_d;
  logic          vrs_q, vrs_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          wack_q, wack_d;
  logic          drvalid_q, drvalid_d;
  logic [DW-1:0] drdata_q, drdata_d;

  logic          xfer_s;
  logic          vrs_rise_s;
  logic          last_beat_s;
  logic [AW-1:0] raddr_next_s;
  logic          fair_force_s;

  assign xfer_s       = mem_valid_q & MEM_READY;
  assign vrs_rise_s   = VRSTART & ~vrs_q;
  assign last_beat_s  = (beat_q == BW'(BURST - 1));
  assign raddr_next_s = (raddr_q == AW'(FRAME_WORDS - 1)) ? AW'(0) : raddr_q + AW'(1);

`ifdef ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_LIM + 1);
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  assign fair_force_s = WREQ & ~wack_q & (starve_cnt_q == SW'(STARVE_LIM));
`else
  assign fair_force_s = 1'b0 & (STARVE_LIM > 0);
`endif

  always_ff @(posedge DCLK or posedge DRST) begin
    if (DRST) begin
      state_q      <= S_IDLE;
      raddr_q      <= AW'(0);
      beat_q       <= BW'(0);
      frame_pend_q <= 1'b0;
      vrs_q        <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= AW'(0);
      mem_wdata_q  <= DW'(0);
      wack_q       <= 1'b0;
      drvalid_q    <= 1'b0;
      drdata_q     <= DW'(0);
`ifdef ARB_FAIR_EN
      starve_cnt_q <= SW'(0);
`endif
    end else begin
      state_q      <= state_d;
      raddr_q      <= raddr_d;
      beat_q       <= beat_d;
      frame_pend_q <= frame_pend_d;
      vrs_q        <= vrs_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wack_q       <= wack_d;
      drvalid_q    <= drvalid_d;
      drdata_q     <= drdata_d;
`ifdef ARB_FAIR_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // A pending frame rewind takes a whole IDLE cycle, so it never races a grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (frame_pend_q) begin
          state_d = S_IDLE;
        end else if (DFIFO_LOW && !fair_force_s) begin
          state_d = S_RD;
        end else if (WREQ && !wack_q) begin
          state_d = S_WR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (xfer_s && last_beat_s) state_d = S_IDLE;
        else                       state_d = S_RD;
      end
      S_WR: begin
        if (xfer_s) state_d = S_IDLE;
        else        state_d = S_WR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    raddr_d      = raddr_q;
    beat_d       = beat_q;
    frame_pend_d = frame_pend_q | vrs_rise_s;
    vrs_d        = VRSTART;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wack_d       = 1'b0;
    drvalid_d    = MEM_RVALID;
    drdata_d     = MEM_RDATA;
`ifdef ARB_FAIR_EN
    starve_cnt_d = starve_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (frame_pend_q) begin
          raddr_d      = AW'(0);
          frame_pend_d = vrs_rise_s;
        end else if (state_d == S_RD) begin
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = raddr_q;
          beat_d      = BW'(0);
        end else if (state_d == S_WR) begin
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = WADDR;
          mem_wdata_d = WDATA;
        end else begin
          mem_valid_d = 1'b0;
        end
      end
      S_RD: begin
        if (xfer_s) begin
          raddr_d = raddr_next_s;
          beat_d  = beat_q + BW'(1);
          if (last_beat_s) begin
            mem_valid_d = 1'b0;
`ifdef ARB_FAIR_EN
            if (!WREQ)                                  starve_cnt_d = SW'(0);
            else if (starve_cnt_q != SW'(STARVE_LIM))   starve_cnt_d = starve_cnt_q + SW'(1);
            else                                        starve_cnt_d = starve_cnt_q;
`endif
          end else begin
            mem_addr_d = raddr_next_s;
          end
        end
      end
      S_WR: begin
        if (xfer_s) begin
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
          wack_d      = 1'b1;
`ifdef ARB_FAIR_EN
          starve_cnt_d = SW'(0);
`endif
        end
      end
      default: begin
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  assign DRVALID   = drvalid_q;
  assign DRDATA    = drdata_q;
  assign WACK      = wack_q;
  assign MEM_VALID = mem_valid_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a full-size instance plus a FRAME_WORDS=64 instance for the wrap.
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int AW = 19;
  localparam int DW = 16;

  logic          dclk = 1'b0, drst = 1'b0, vrstart = 1'b0, dfifo_low = 1'b0;
  logic          wreq = 1'b0, mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0, mem_rdata = '0;
  logic          drvalid, wack, mem_valid, mem_we;
  logic [DW-1:0] drdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          s_drvalid, s_wack, s_valid, s_we;
  logic [DW-1:0] s_drdata, s_wdata;
  logic [AW-1:0] s_addr;

  vram_arbiter dut (
    .DCLK(dclk), .DRST(drst), .VRSTART(vrstart), .DFIFO_LOW(dfifo_low),
    .DRVALID(drvalid), .DRDATA(drdata), .WREQ(wreq), .WADDR(waddr), .WDATA(wdata),
    .WACK(wack), .MEM_VALID(mem_valid), .MEM_READY(mem_ready), .MEM_WE(mem_we),
    .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_RVALID(mem_rvalid), .MEM_RDATA(mem_rdata)
  );

  vram_arbiter #(.FRAME_WORDS(64)) dut_small (
    .DCLK(dclk), .DRST(drst), .VRSTART(1'b0), .DFIFO_LOW(dfifo_low),
    .DRVALID(s_drvalid), .DRDATA(s_drdata), .WREQ(1'b0), .WADDR(waddr), .WDATA(wdata),
    .WACK(s_wack), .MEM_VALID(s_valid), .MEM_READY(mem_ready), .MEM_WE(s_we),
    .MEM_ADDR(s_addr), .MEM_WDATA(s_wdata), .MEM_RVALID(mem_rvalid), .MEM_RDATA(mem_rdata)
  );

  always #5 dclk = ~dclk;

  int total = 0, bad = 0, cyc = 0;
  int xa[$], xw[$], xd[$], xt[$], sa[$], aq[$];
  logic vq[$], rq[$];

  // Transfer log: at the falling edge, VALID&READY means a transfer on the next rising edge.
  always @(negedge dclk) begin
    if (!drst) begin
      cyc = cyc + 1;
      vq.push_back(mem_valid);
      rq.push_back(mem_ready);
      aq.push_back(int'(mem_addr));
      if (mem_valid && mem_ready) begin
        xa.push_back(int'(mem_addr));
        xw.push_back(int'(mem_we));
        xd.push_back(int'(mem_wdata));
        xt.push_back(cyc);
      end
      if (s_valid && mem_ready) sa.push_back(int'(s_addr));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge dclk);
    #1;
  endtask

  task automatic clr();
    xa.delete(); xw.delete(); xd.delete(); xt.delete();
    sa.delete(); aq.delete(); vq.delete(); rq.delete();
    cyc = 0;
  endtask

  initial begin
    int n;
    int j;
    int wcnt;
    #2 drst = 1'b1;
    tick(3);
    check("rst_valid", mem_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wack", wack, 0);
    check("rst_drvalid", drvalid, 0);
    check("rst_we", mem_we, 0);

    // Back-to-back bursts with memory always ready
    clr(); dfifo_low = 1'b1; mem_ready = 1'b1; drst = 1'b0;
    tick(90);
    check("p1_count", xa.size() >= 32, 1);
    if (xa.size() >= 32) begin
      for (int i = 0; i < 32; i++) begin
        check("p1_addr", xa[i], i);
        check("p1_read", xw[i], 0);
      end
      check("p1_burst_span", xt[15] - xt[0], 15);
      check("p1_gap", xt[16] - xt[15], 2);
    end
    check("fw64_count", sa.size() >= 65, 1);
    if (sa.size() >= 65)
      for (int k = 0; k < 5; k++) check("fw64_start", sa[16*k], (16*k) % 64);

    // Read return path: one-cycle latency, data registered unconditionally
    mem_rvalid = 1'b1; mem_rdata = 16'h5A3C;
    #2 check("rd_lat0", drvalid, 0);
    tick(1);
    check("rd_valid", drvalid, 1);
    check("rd_data", drdata, 16'h5A3C);
    mem_rvalid = 1'b0; mem_rdata = 16'h1111;
    tick(1);
    check("rd_valid_off", drvalid, 0);
    check("rd_data_ungated", drdata, 16'h1111);

    // Reset while a command is stalled
    mem_ready = 1'b0;
    tick(3);
    check("stall_valid", mem_valid, 1);
    drst = 1'b1;
    #1 check("async_rst_valid", mem_valid, 0);
    tick(2);

    // Alternating READY: each address held until its transfer
    clr(); drst = 1'b0;
    for (int i = 0; i < 90; i++) begin
      mem_ready = (i % 2 == 1);
      tick(1);
    end
    check("p2_count", xa.size() >= 32, 1);
    if (xa.size() >= 32) begin
      for (int i = 0; i < 32; i++) check("p2_addr", xa[i], i);
      check("p2_burst_end", vq[xt[15]], 0);
    end
    for (int i = 0; i + 1 < vq.size(); i++) begin
      if (vq[i] && !rq[i]) begin
        check("p2_hold_valid", vq[i+1], 1);
        check("p2_hold_addr", aq[i+1], aq[i]);
      end
    end

    // Single draw write with display idle
    drst = 1'b1; tick(2);
    clr(); dfifo_low = 1'b0; mem_ready = 1'b1; wreq = 1'b1;
    waddr = 19'h01234; wdata = 16'hBEEF; drst = 1'b0;
    n = 0;
    while (!wack && n < 20) begin tick(1); n++; end
    check("wr_wack_seen", wack, 1);
    check("wr_latency", n, 2);
    tick(1);
    check("wr_wack_pulse", wack, 0);
    wreq = 1'b0;
    tick(5);
    check("wr_count", xa.size(), 1);
    if (xa.size() >= 1) begin
      check("wr_we", xw[0], 1);
      check("wr_addr", xa[0], 32'h01234);
      check("wr_data", xd[0], 32'hBEEF);
    end

    // Display demand and write request both held
    drst = 1'b1; tick(2);
    clr(); dfifo_low = 1'b1; wreq = 1'b1; waddr = 19'h00777; wdata = 16'h1234; drst = 1'b0;
    tick(170);
`ifdef ARB_FAIR_EN
    check("fair_count", xa.size() >= 130, 1);
    if (xa.size() >= 130) begin
      wcnt = 0;
      for (int i = 0; i < 130; i++) wcnt += xw[i];
      check("fair_writes", wcnt, 2);
      check("fair_w1", xw[64], 1);
      check("fair_w1_addr", xa[64], 32'h777);
      check("fair_resume", xa[65], 64);
      check("fair_w2", xw[129], 1);
    end
    wreq = 1'b0;
`else
    wcnt = 0;
    for (int i = 0; i < xw.size(); i++) wcnt += xw[i];
    check("nofair_no_write", wcnt, 0);
    check("nofair_reads", xa.size() >= 140, 1);
    dfifo_low = 1'b0;
    n = 0;
    while (!wack && n < 40) begin tick(1); n++; end
    check("nofair_wack", wack, 1);
    wreq = 1'b0;
    check("nofair_last_we", xw[xw.size()-1], 1);
    check("nofair_last_addr", xa[xa.size()-1], 32'h777);
`endif

    // Frame restart arriving mid-burst
    drst = 1'b1; tick(2);
    clr(); dfifo_low = 1'b1; wreq = 1'b0; mem_ready = 1'b1; drst = 1'b0;
    n = 0;
    while (!(mem_valid && mem_addr == 19'd324) && n < 1000) begin tick(1); n++; end
    check("vs_reach_324", mem_addr, 324);
    vrstart = 1'b1;
    tick(40);
    vrstart = 1'b0;
    tick(5);
    j = -1;
    for (int i = 0; i < xa.size(); i++) if (xa[i] == 320 && j < 0) j = i;
    check("vs_found_320", j >= 0 && xa.size() >= j + 18, 1);
    if (j >= 0 && xa.size() >= j + 18) begin
      for (int k = 0; k < 16; k++) check("vs_burst_done", xa[j+k], 320 + k);
      check("vs_rewind0", xa[j+16], 0);
      check("vs_rewind1", xa[j+17], 1);
      check("vs_rewind_gap", xt[j+16] - xt[j+15], 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
